// File: rtl/inst_buffer_if.sv
// Packet type and fetch/dispatch-facing bundle for the instruction buffer.
// The master modport belongs to the fetch/dispatch side, and the slave modport to the buffer.
package inst_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        halt;
        logic        br_pred_taken;
        logic [31:0] br_pred_target;
    } IF_ID_PACKET;
endpackage

interface inst_buffer_if #(
    parameter int DEPTH = 8
);
    import inst_buffer_pkg::*;
    localparam int CW = $clog2(DEPTH + 1);

    IF_ID_PACKET [2:0] if_packet_in;
    logic              fetch_stall;
    IF_ID_PACKET [2:0] if_id_packet_out;
    logic [2:0]        d_stall;
    logic [CW-1:0]     count;

    modport master (
        output if_packet_in,
        output d_stall,
        input  fetch_stall,
        input  if_id_packet_out,
        input  count
    );

    modport slave (
        input  if_packet_in,
        input  d_stall,
        output fetch_stall,
        output if_id_packet_out,
        output count
    );
endinterface

// File: rtl/inst_buffer.sv
// Three-wide in-order circular instruction queue between fetch and dispatch.
// The three oldest entries are presented each cycle and retire through the thermometer d_stall.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          squash,
    inst_buffer_if.slave  ib
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    IF_ID_PACKET       entry_q [DEPTH];
    IF_ID_PACKET       entry_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;

    IF_ID_PACKET [2:0] out_pkt;
    logic [PW-1:0]     rd_idx [WIDTH];
    logic [PW-1:0]     wr_idx [WIDTH];
    logic [2:0]        slot_ok;
    logic [2:0]        wr_en;
    logic [1:0]        n_disp;
    logic [1:0]        m_enq;
    logic              fetch_stall;

    // Uses only the registered count, so d_stall never has a combinational path to fetch.
    assign fetch_stall = (count_q > CW'(DEPTH - 3));

    // Slot gi sits at age WIDTH-1-gi from head; pointer wrap is free because DEPTH is a power of two.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_slot
        localparam int AGE = WIDTH - 1 - gi;
        assign rd_idx[gi]  = head_q + PW'(AGE);
        assign wr_idx[gi]  = tail_q + PW'(AGE);
        assign out_pkt[gi] = (count_q > CW'(AGE)) ? entry_q[rd_idx[gi]] : '0;
        assign wr_en[gi]   = ~fetch_stall & ib.if_packet_in[gi].valid;
    end

    // Chained enables stop dispatch at the first stalled slot, even if a younger slot disagrees.
    always_comb begin
        slot_ok    = '0;
        slot_ok[2] = out_pkt[2].valid & ~ib.d_stall[2];
        slot_ok[1] = slot_ok[2] & out_pkt[1].valid & ~ib.d_stall[1];
        slot_ok[0] = slot_ok[1] & out_pkt[0].valid & ~ib.d_stall[0];
        n_disp     = {1'b0, slot_ok[2]} + {1'b0, slot_ok[1]} + {1'b0, slot_ok[0]};
        m_enq      = {1'b0, wr_en[2]} + {1'b0, wr_en[1]} + {1'b0, wr_en[0]};
    end

    always_comb begin
        entry_d = entry_q;
        if (squash) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
            end
        end else begin
            for (int k = 0; k < WIDTH; k++) begin
                if (wr_en[k]) begin
                    entry_d[wr_idx[k]] = ib.if_packet_in[k];
                end
            end
        end
    end

    always_comb begin
        head_d  = head_q + PW'(n_disp);
        tail_d  = tail_q + PW'(m_enq);
        count_d = count_q + CW'(m_enq) - CW'(n_disp);
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            entry_q <= entry_d;
        end
    end

    assign ib.if_id_packet_out = out_pkt;
    assign ib.fetch_stall      = fetch_stall;
    assign ib.count            = count_q;

    // A younger valid slot must never be released after an older one stalled.
    a_d_stall_thermo: assert property (@(posedge clock) disable iff (!reset)
        !(out_pkt[1].valid && ib.d_stall[2] && !ib.d_stall[1]) &&
        !(out_pkt[0].valid && ib.d_stall[1] && !ib.d_stall[0]));

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer (DEPTH=8): flow, partial dispatch,
// full/stall, wrap-around, squash and asynchronous reset.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    logic clock  = 1'b0;
    logic reset  = 1'b0;
    logic squash = 1'b0;
    int   n_cmp  = 0;
    int   n_mis  = 0;
    int   cyc    = 0;

    inst_buffer_if #(.DEPTH(8)) ibus ();

    inst_buffer #(.DEPTH(8), .WIDTH(3)) dut (
        .clock  (clock),
        .reset  (reset),
        .squash (squash),
        .ib     (ibus.slave)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic IF_ID_PACKET mk(input logic [31:0] pc);
        IF_ID_PACKET p;
        p                = '0;
        p.valid          = 1'b1;
        p.inst           = 32'h1300_0013 ^ pc;
        p.pc             = pc;
        p.npc            = pc + 32'd4;
        p.br_pred_taken  = pc[2];
        p.br_pred_target = pc + 32'h100;
        return p;
    endfunction

    // Slot 2 gets pc0, slot 1 pc0+4, slot 0 pc0+8; only the first nv slots are valid.
    task automatic drive_group(input logic [31:0] pc0, input int nv);
        for (int j = 0; j < 3; j++) begin
            ibus.if_packet_in[2-j] = (j < nv) ? mk(pc0 + 32'(4 * j)) : '0;
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
        cyc++;
        $display("cyc %0d count=%0d fetch_stall=%0b slot2 v=%0b pc=0x%0h", cyc, ibus.count,
                 ibus.fetch_stall, ibus.if_id_packet_out[2].valid, ibus.if_id_packet_out[2].pc);
    endtask

    task automatic check_slots(input string tag, input int nv, input logic [31:0] pc0);
        for (int j = 0; j < 3; j++) begin
            if (j < nv) begin
                check_val($sformatf("%s_s%0d_v", tag, 2-j), 64'(ibus.if_id_packet_out[2-j].valid), 64'd1);
                check_val($sformatf("%s_s%0d_pc", tag, 2-j), 64'(ibus.if_id_packet_out[2-j].pc),
                          64'(pc0 + 32'(4 * j)));
            end else begin
                check_val($sformatf("%s_s%0d_zero", tag, 2-j), 64'(ibus.if_id_packet_out[2-j] != '0), 64'd0);
            end
        end
    endtask

    task automatic check_state(input string tag, input int cnt, input logic fs);
        check_val({tag, "_count"}, 64'(ibus.count), 64'(cnt));
        check_val({tag, "_fstall"}, 64'(ibus.fetch_stall), 64'(fs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] pc_next;
        logic [2:0]  ds;
        int          groups;
        int          n;
        bit          accept;

        ibus.if_packet_in = '0;
        ibus.d_stall      = 3'b111;

        // Reset held, then released
        repeat (2) @(posedge clock);
        #1;
        check_state("rst_held", 0, 1'b0);
        check_slots("rst_held", 0, 32'h0);
        reset = 1'b1;
        tick;
        check_state("rst_rel", 0, 1'b0);
        check_slots("rst_rel", 0, 32'h0);

        // Steady flow: group 0/4/8, next cycle visible, then fully dispatched
        drive_group(32'h0, 3);
        ibus.d_stall = 3'b000;
        tick;
        ibus.if_packet_in = '0;
        check_state("flow", 3, 1'b0);
        check_slots("flow", 3, 32'h0);
        check_val("flow_s2_npc", 64'(ibus.if_id_packet_out[2].npc), 64'h4);
        check_val("flow_s1_bp", 64'(ibus.if_id_packet_out[1].br_pred_taken), 64'd1);
        check_val("flow_s0_bt", 64'(ibus.if_id_packet_out[0].br_pred_target), 64'h108);
        tick;
        check_state("flow_drain", 0, 1'b0);
        check_slots("flow_drain", 0, 32'h0);

        // Partial dispatch with d_stall=011
        drive_group(32'hC, 3);
        ibus.d_stall = 3'b111;
        tick;
        ibus.if_packet_in = '0;
        check_state("part_fill", 3, 1'b0);
        check_slots("part_fill", 3, 32'hC);
        ibus.d_stall = 3'b011;
        tick;
        check_state("part_one", 2, 1'b0);
        check_slots("part_one", 2, 32'h10);
        ibus.d_stall = 3'b000;
        tick;
        check_state("part_drain", 0, 1'b0);

        // Fill and stall
        ibus.d_stall = 3'b111;
        drive_group(32'h18, 3);
        tick;
        check_state("fill1", 3, 1'b0);
        drive_group(32'h24, 3);
        tick;
        check_state("fill2", 6, 1'b1);
        drive_group(32'h30, 3);
        tick;
        check_state("fill_held", 6, 1'b1);
        check_slots("fill_held", 3, 32'h18);
        ibus.d_stall = 3'b000;
        tick;
        check_state("fill_rel", 3, 1'b0);
        check_slots("fill_rel", 3, 32'h24);
        tick;
        ibus.if_packet_in = '0;
        check_state("fill_late", 3, 1'b0);
        check_slots("fill_late", 3, 32'h30);
        tick;
        check_state("fill_drain", 0, 1'b0);

        // Wrap-around: five groups, alternating 011/000, against a PC queue
        pc_next = 32'h40;
        groups  = 5;
        for (int it = 0; it < 40 && (groups > 0 || q.size() > 0); it++) begin
            check_val($sformatf("wrap%0d_count", it), 64'(ibus.count), 64'(q.size()));
            check_val($sformatf("wrap%0d_fstall", it), 64'(ibus.fetch_stall), 64'(q.size() > 5));
            for (int j = 0; j < 3; j++) begin
                if (j < q.size()) begin
                    check_val($sformatf("wrap%0d_s%0d_pc", it, 2-j),
                              64'(ibus.if_id_packet_out[2-j].pc), 64'(q[j]));
                end else begin
                    check_val($sformatf("wrap%0d_s%0d_v", it, 2-j),
                              64'(ibus.if_id_packet_out[2-j].valid), 64'd0);
                end
            end
            ds     = (it % 2 == 1) ? 3'b000 : 3'b011;
            accept = (q.size() <= 5) && (groups > 0);
            if (accept) drive_group(pc_next, 3);
            else ibus.if_packet_in = '0;
            ibus.d_stall = ds;
            n = (ds == 3'b011) ? 1 : 3;
            if (n > q.size()) n = q.size();
            tick;
            repeat (n) void'(q.pop_front());
            if (accept) begin
                for (int j = 0; j < 3; j++) q.push_back(pc_next + 32'(4 * j));
                pc_next = pc_next + 32'd12;
                groups--;
            end
        end
        ibus.if_packet_in = '0;
        check_val("wrap_done", 64'(q.size()), 64'd0);
        check_state("wrap_end", 0, 1'b0);

        // Squash with count=5 and a simultaneous valid group
        ibus.d_stall = 3'b111;
        drive_group(32'h100, 3);
        tick;
        drive_group(32'h10C, 2);
        tick;
        check_state("sq_pre", 5, 1'b0);
        check_slots("sq_pre", 3, 32'h100);
        drive_group(32'h200, 3);
        squash = 1'b1;
        tick;
        squash = 1'b0;
        ibus.if_packet_in = '0;
        check_state("sq_now", 0, 1'b0);
        check_slots("sq_now", 0, 32'h0);
        tick;
        check_state("sq_after", 0, 1'b0);
        check_slots("sq_after", 0, 32'h0);
        drive_group(32'h300, 3);
        tick;
        ibus.if_packet_in = '0;
        check_state("sq_new", 3, 1'b0);
        check_slots("sq_new", 3, 32'h300);

        // Asynchronous reset between clock edges
        #3;
        reset = 1'b0;
        #1;
        check_state("arst", 0, 1'b0);
        check_slots("arst", 0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick;
        check_state("arst_rel", 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
